// File: rtl/ui_pkg.sv
// Shared types and constants for the user interface set sequencer.
package ui_pkg;
    localparam int          START_BIT       = 16;
    localparam logic [31:0] FLG_SET         = 32'd4;
    localparam logic [31:0] FLG_ALL         = 32'd8;
    localparam int          DEF_ADDR_W      = 21;
    localparam int          DEF_SET_STRIDE  = 1665;
    localparam int          DEF_TEM_WORDS   = 64;
    localparam int          DEF_WIN_WORDS   = 1600;

    typedef enum logic [3:0] {
        IDLE, RD_HDR, SET_START, RD_TEM, RD_WIN, WAIT_ENG, WR_RES, FLAG_SET, FLAG_DONE
    } state_t;

    // What the read accepted last cycle will return this cycle
    typedef enum logic [1:0] {P_NONE, P_HDR, P_TEM, P_WIN} pend_t;

    // Word-offset register operations
    typedef enum logic [1:0] {OFF_HOLD, OFF_CLR, OFF_ONE, OFF_INC} off_op_t;
endpackage

// File: rtl/user_interface_ctrl_if.sv
// Memory-side bus: read request/response plus write strobe on a shared address.
interface user_interface_ctrl_if #(parameter int ADDR_W = 21);
    logic              rd_req;
    logic              rd_ready;
    logic [31:0]       rd_data;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       write_data;
    logic              FPGA_wr_en;

    modport master (output rd_req, req_addr, write_data, FPGA_wr_en,
                    input  rd_ready, rd_data);
    modport slave  (input  rd_req, req_addr, write_data, FPGA_wr_en,
                    output rd_ready, rd_data);
endinterface

// File: rtl/user_interface_ctrl_addr_gen.sv
// Set counter, word offset and memory address generation.
// Data area address = s*SET_STRIDE + off; result area = RES_BASE + 3*s + off.
module ui_addr_gen
    import ui_pkg::*;
#(
    parameter int                ADDR_W     = DEF_ADDR_W,
    parameter int                SET_STRIDE = DEF_SET_STRIDE,
    parameter logic [ADDR_W-1:0] RES_BASE   = 21'h1F0000,
    parameter int                OFF_W      = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_clr,
    input  logic              set_inc,
    input  off_op_t           off_op,
    input  logic              res_mode,
    output logic [7:0]        set_cnt,
    output logic [OFF_W-1:0]  off,
    output logic [ADDR_W-1:0] addr
);
    logic [ADDR_W-1:0] base;

    // Set counter and word offset registers
    always_ff @(posedge clk) begin
        if (rst) begin
            set_cnt <= '0;
            off     <= '0;
        end else begin
            if (set_clr)      set_cnt <= '0;
            else if (set_inc) set_cnt <= set_cnt + 8'd1;
            case (off_op)
                OFF_CLR: off <= '0;
                OFF_ONE: off <= OFF_W'(1);
                OFF_INC: off <= off + OFF_W'(1);
                default: ;
            endcase
        end
    end

    // Base select and offset add; all arithmetic wraps at ADDR_W bits
    always_comb begin
        base = res_mode ? RES_BASE + ADDR_W'(3) * ADDR_W'(set_cnt)
                        : ADDR_W'(set_cnt) * ADDR_W'(SET_STRIDE);
        addr = base + ADDR_W'(off);
    end
endmodule

// File: rtl/user_interface_ctrl.sv
// Set sequencer: reads header, streams template/window words per set to the
// NCC engine, writes back the engine result and raises completion flags.
module user_interface_ctrl
    import ui_pkg::*;
#(
    parameter int                ADDR_W     = DEF_ADDR_W,
    parameter int                SET_STRIDE = DEF_SET_STRIDE,
    parameter int                TEM_WORDS  = DEF_TEM_WORDS,
    parameter int                WIN_WORDS  = DEF_WIN_WORDS,
    parameter logic [ADDR_W-1:0] RES_BASE   = 21'h1F0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          in_flag,
    input  logic [31:0]          pci_input_data,
    input  logic [ADDR_W-1:0]    pci_req_addr,
    input  logic                 pci_wr_en,
    user_interface_ctrl_if.master mem,
    output logic [31:0]          out_flag,
    output logic                 flag_we,
    output logic [31:0]          tem_data,
    output logic                 tem_valid,
    output logic [31:0]          win_data,
    output logic                 win_valid,
    output logic                 set_start,
    input  logic                 eng_done,
    input  logic [63:0]          eng_ncc,
    input  logic [12:0]          eng_idx,
    output logic [63:0]          greatestNCCLog2,
    output logic [12:0]          greatestWindowIndex
);
    localparam int OFF_W = $clog2(SET_STRIDE + 1);

    state_t            state, nxt;
    pend_t             pend, issue;
    logic [7:0]        n_sets;
    logic [7:0]        set_cnt;
    logic [OFF_W-1:0]  off;
    logic [ADDR_W-1:0] addr;
    logic              set_clr, set_inc, res_mode;
    off_op_t           off_op;
    logic              unused_flag;

    assign unused_flag = ^{in_flag[31:START_BIT+1], in_flag[START_BIT-1:0]};

    ui_addr_gen #(
        .ADDR_W(ADDR_W), .SET_STRIDE(SET_STRIDE), .RES_BASE(RES_BASE), .OFF_W(OFF_W)
    ) u_addr (
        .clk(clk), .rst(rst), .set_clr(set_clr), .set_inc(set_inc),
        .off_op(off_op), .res_mode(res_mode),
        .set_cnt(set_cnt), .off(off), .addr(addr)
    );

    // State, in-flight read tag, stream outputs and result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= IDLE;
            pend                <= P_NONE;
            n_sets              <= '0;
            tem_data            <= '0;
            tem_valid           <= 1'b0;
            win_data            <= '0;
            win_valid           <= 1'b0;
            greatestNCCLog2     <= '0;
            greatestWindowIndex <= '0;
        end else begin
            state     <= nxt;
            pend      <= issue;
            tem_valid <= (pend == P_TEM);
            win_valid <= (pend == P_WIN);
            if (pend == P_TEM) tem_data <= mem.rd_data;
            if (pend == P_WIN) win_data <= mem.rd_data;
            if (state == RD_HDR && pend == P_HDR) n_sets <= mem.rd_data[7:0];
            if (state == WAIT_ENG && eng_done) begin
                greatestNCCLog2     <= eng_ncc;
                greatestWindowIndex <= eng_idx;
            end
        end
    end

    // Next-state, bus drive and strobes
    always_comb begin
        nxt            = state;
        issue          = P_NONE;
        set_clr        = 1'b0;
        set_inc        = 1'b0;
        off_op         = OFF_HOLD;
        res_mode       = 1'b0;
        mem.rd_req     = 1'b0;
        mem.req_addr   = addr;
        mem.write_data = '0;
        mem.FPGA_wr_en = 1'b0;
        out_flag       = '0;
        flag_we        = 1'b0;
        set_start      = 1'b0;
        case (state)
            IDLE: begin
                mem.req_addr   = pci_req_addr;
                mem.write_data = pci_input_data;
                mem.FPGA_wr_en = pci_wr_en;
                if (in_flag[START_BIT]) begin
                    set_clr = 1'b1;
                    off_op  = OFF_CLR;
                    nxt     = RD_HDR;
                end
            end
            RD_HDR: begin
                if (pend == P_HDR) begin
                    nxt = (mem.rd_data[7:0] == 8'd0) ? FLAG_DONE : SET_START;
                end else begin
                    mem.rd_req = 1'b1;
                    if (mem.rd_ready) issue = P_HDR;
                end
            end
            SET_START: begin
                set_start = 1'b1;
                off_op    = OFF_ONE;
                nxt       = RD_TEM;
            end
            RD_TEM: begin
                mem.rd_req = 1'b1;
                if (mem.rd_ready) begin
                    issue  = P_TEM;
                    off_op = OFF_INC;
                    if (off == OFF_W'(TEM_WORDS)) nxt = RD_WIN;
                end
            end
            RD_WIN: begin
                mem.rd_req = 1'b1;
                if (mem.rd_ready) begin
                    issue  = P_WIN;
                    off_op = OFF_INC;
                    if (off == OFF_W'(TEM_WORDS + WIN_WORDS)) nxt = WAIT_ENG;
                end
            end
            WAIT_ENG: begin
                if (eng_done) begin
                    off_op = OFF_CLR;
                    nxt    = WR_RES;
                end
            end
            WR_RES: begin
                res_mode       = 1'b1;
                mem.FPGA_wr_en = 1'b1;
                off_op         = OFF_INC;
                case (off)
                    OFF_W'(0): mem.write_data = greatestNCCLog2[63:32];
                    OFF_W'(1): mem.write_data = greatestNCCLog2[31:0];
                    default:   mem.write_data = {19'b0, greatestWindowIndex};
                endcase
                if (off == OFF_W'(2)) nxt = FLAG_SET;
            end
            FLAG_SET: begin
                out_flag = FLG_SET;
                flag_we  = 1'b1;
                set_inc  = 1'b1;
                nxt = ({1'b0, set_cnt} + 9'd1 < {1'b0, n_sets}) ? SET_START : FLAG_DONE;
            end
            FLAG_DONE: begin
                out_flag = FLG_ALL;
                flag_we  = 1'b1;
                nxt      = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_user_interface_ctrl.sv
// Directed bench for the set sequencer with a one-cycle-latency memory model.
module tb_user_interface_ctrl;
    localparam logic [20:0] RES_BASE = 21'h1F0000;

    logic        clk, rst;
    logic [31:0] in_flag, pci_input_data;
    logic [20:0] pci_req_addr;
    logic        pci_wr_en;
    logic [31:0] out_flag, tem_data, win_data;
    logic        flag_we, tem_valid, win_valid, set_start;
    logic        eng_done;
    logic [63:0] eng_ncc, greatestNCCLog2;
    logic [12:0] eng_idx, greatestWindowIndex;

    user_interface_ctrl_if #(.ADDR_W(21)) mem ();

    user_interface_ctrl dut (
        .clk(clk), .rst(rst), .in_flag(in_flag), .pci_input_data(pci_input_data),
        .pci_req_addr(pci_req_addr), .pci_wr_en(pci_wr_en), .mem(mem),
        .out_flag(out_flag), .flag_we(flag_we), .tem_data(tem_data), .tem_valid(tem_valid),
        .win_data(win_data), .win_valid(win_valid), .set_start(set_start),
        .eng_done(eng_done), .eng_ncc(eng_ncc), .eng_idx(eng_idx),
        .greatestNCCLog2(greatestNCCLog2), .greatestWindowIndex(greatestWindowIndex)
    );

    int n_vec = 0, n_err = 0;
    int rd_cnt, tem_cnt, win_cnt, rd_err, tem_err, win_err;
    logic [31:0] hdr_val;
    bit          data_mode, rnd_ready, log_wr;
    logic [20:0] exp_rd[$];
    logic [31:0] exp_tem[$], exp_win[$], flag_log[$];
    logic [52:0] wr_log[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_val(input logic [20:0] a);
        if (a == 21'd0) return hdr_val;
        return data_mode ? {11'h2A5, a} : 32'h41434143;
    endfunction

    // Memory: data one cycle after an accepted read, junk otherwise
    always @(posedge clk) begin
        if (mem.rd_req && mem.rd_ready) mem.rd_data <= mem_val(mem.req_addr);
        else                            mem.rd_data <= 32'hBAD0BAD0;
    end

    initial begin
        mem.rd_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1 mem.rd_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: read order, stream contents, writes and flags
    always @(negedge clk) begin
        if (!rst) begin
            if (mem.rd_req && mem.rd_ready) begin
                rd_cnt++;
                if (exp_rd.size() == 0) rd_err++;
                else if (mem.req_addr !== exp_rd.pop_front()) rd_err++;
            end
            if (tem_valid) begin
                tem_cnt++;
                if (exp_tem.size() == 0) tem_err++;
                else if (tem_data !== exp_tem.pop_front()) tem_err++;
            end
            if (win_valid) begin
                win_cnt++;
                if (exp_win.size() == 0) win_err++;
                else if (win_data !== exp_win.pop_front()) win_err++;
            end
            if (mem.FPGA_wr_en && log_wr) wr_log.push_back({mem.req_addr, mem.write_data});
            if (flag_we) flag_log.push_back(out_flag);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected stream for n sets; clears all logs and counters
    task automatic build(input int n, input bit mode);
        hdr_val = 32'(n); data_mode = mode;
        exp_rd.delete(); exp_tem.delete(); exp_win.delete(); wr_log.delete(); flag_log.delete();
        rd_cnt = 0; tem_cnt = 0; win_cnt = 0; rd_err = 0; tem_err = 0; win_err = 0;
        exp_rd.push_back(21'd0);
        for (int s = 0; s < n; s++) begin
            for (int k = 1; k <= 1664; k++) begin
                exp_rd.push_back(21'(s * 1665 + k));
                if (k <= 64) exp_tem.push_back(mem_val(21'(s * 1665 + k)));
                else         exp_win.push_back(mem_val(21'(s * 1665 + k)));
            end
        end
    endtask

    // which: 0 win_cnt, 1 flags logged, 2 reads accepted
    task automatic wait_for(input string tag, input int which, input int target, input int budget);
        bit ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(posedge clk); #1;
            ok = (which == 0) ? (win_cnt >= target) :
                 (which == 1) ? (flag_log.size() >= target) : (rd_cnt >= target);
        end
        check({tag, "_reached"}, 64'(ok), 64'd1);
    endtask

    task automatic pulse_start();
        in_flag = 32'h0001_0000;
        @(posedge clk); #1 in_flag = 32'h0;
    endtask

    task automatic pulse_eng(input logic [63:0] ncc, input logic [12:0] idx);
        eng_done = 1'b1; eng_ncc = ncc; eng_idx = idx;
        @(posedge clk); #1 eng_done = 1'b0;
    endtask

    task automatic check_wr(input string tag, input logic [20:0] a, input logic [31:0] d);
        logic [52:0] e;
        e = (wr_log.size() == 0) ? '1 : wr_log.pop_front();
        check({tag, "_addr"}, 64'(e[52:32]), 64'(a));
        check({tag, "_data"}, 64'(e[31:0]), 64'(d));
    endtask

    task automatic check_flag(input string tag, input logic [31:0] f);
        logic [31:0] e;
        e = (flag_log.size() == 0) ? '1 : flag_log.pop_front();
        check(tag, 64'(e), 64'(f));
    endtask

    task automatic check_stream(input string tag, input int sets);
        check({tag, "_rd_cnt"},  64'(rd_cnt),  64'(1 + 1664 * sets));
        check({tag, "_tem_cnt"}, 64'(tem_cnt), 64'(64 * sets));
        check({tag, "_win_cnt"}, 64'(win_cnt), 64'(1600 * sets));
        check({tag, "_rd_order"}, 64'(rd_err + exp_rd.size()), 64'd0);
        check({tag, "_tem_data"}, 64'(tem_err), 64'd0);
        check({tag, "_win_data"}, 64'(win_err), 64'd0);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_flag_we"},  64'(flag_we),        64'd0);
        check({tag, "_out_flag"}, 64'(out_flag),       64'd0);
        check({tag, "_tem_vld"},  64'(tem_valid),      64'd0);
        check({tag, "_win_vld"},  64'(win_valid),      64'd0);
        check({tag, "_set_st"},   64'(set_start),      64'd0);
        check({tag, "_rd_req"},   64'(mem.rd_req),     64'd0);
        check({tag, "_wr_en"},    64'(mem.FPGA_wr_en), 64'd0);
        check({tag, "_addr"},     64'(mem.req_addr),   64'd0);
    endtask

    initial begin
        rst = 1'b1; in_flag = '0; pci_input_data = '0; pci_req_addr = '0; pci_wr_en = 1'b0;
        eng_done = 1'b0; eng_ncc = '0; eng_idx = '0;
        rnd_ready = 0; log_wr = 0; hdr_val = 32'd1; data_mode = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_quiet("reset");
        check("reset_ncc", greatestNCCLog2, 64'd0);
        check("reset_idx", 64'(greatestWindowIndex), 64'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Idle host write is mirrored the same cycle
        pci_req_addr = 21'h10; pci_input_data = 32'hDEAD; pci_wr_en = 1'b1;
        @(negedge clk);
        check("idle_wr_en",   64'(mem.FPGA_wr_en), 64'd1);
        check("idle_wr_addr", 64'(mem.req_addr),   64'h10);
        check("idle_wr_data", 64'(mem.write_data), 64'hDEAD);
        @(posedge clk); #1 pci_wr_en = 1'b0; pci_req_addr = '0; pci_input_data = '0;

        // One set, constant data, ready always high
        build(1, 0); log_wr = 1;
        pulse_start();
        wait_for("run1_tem", 2, 10, 100);
        pulse_eng(64'hFFFF_FFFF_FFFF_FFFF, 13'd7);
        @(negedge clk);
        check("eng_ignored_ncc", greatestNCCLog2, 64'd0);
        @(posedge clk); #1;
        pci_req_addr = 21'h10; pci_input_data = 32'hDEAD; pci_wr_en = 1'b1;
        @(negedge clk);
        check("busy_wr_dropped", 64'(mem.FPGA_wr_en), 64'd0);
        @(posedge clk); #1 pci_wr_en = 1'b0; pci_req_addr = '0; pci_input_data = '0;
        wait_for("run1_win", 0, 1600, 20000);
        pulse_eng(64'h0000_0003_8000_0000, 13'd5);
        wait_for("run1_flags", 1, 2, 100);
        check_stream("run1", 1);
        check("run1_wr_n", 64'(wr_log.size()), 64'd3);
        check_wr("run1_w0", RES_BASE,         32'h3);
        check_wr("run1_w1", RES_BASE + 21'd1, 32'h8000_0000);
        check_wr("run1_w2", RES_BASE + 21'd2, 32'h5);
        check("run1_flag_n", 64'(flag_log.size()), 64'd2);
        check_flag("run1_f0", 32'd4);
        check_flag("run1_f1", 32'd8);
        check("run1_ncc", greatestNCCLog2, 64'h0000_0003_8000_0000);
        check("run1_idx", 64'(greatestWindowIndex), 64'd5);

        // Two sets, address-tagged data, random ready, start while busy
        build(2, 1); rnd_ready = 1;
        pulse_start();
        wait_for("run2_rd", 2, 200, 2000);
        pulse_start();
        wait_for("run2_win0", 0, 1600, 20000);
        pulse_eng(64'h1234_5678_9ABC_DEF0, 13'd100);
        wait_for("run2_win1", 0, 3200, 20000);
        pulse_eng(64'h0000_0011_0000_0022, 13'd1599);
        wait_for("run2_flags", 1, 3, 200);
        rnd_ready = 0;
        repeat (20) @(posedge clk);
        #1;
        check_stream("run2", 2);
        check("run2_wr_n", 64'(wr_log.size()), 64'd6);
        check_wr("run2_s0w0", RES_BASE,         32'h1234_5678);
        check_wr("run2_s0w1", RES_BASE + 21'd1, 32'h9ABC_DEF0);
        check_wr("run2_s0w2", RES_BASE + 21'd2, 32'd100);
        check_wr("run2_s1w0", RES_BASE + 21'd3, 32'h11);
        check_wr("run2_s1w1", RES_BASE + 21'd4, 32'h22);
        check_wr("run2_s1w2", RES_BASE + 21'd5, 32'd1599);
        check("run2_flag_n", 64'(flag_log.size()), 64'd3);
        check_flag("run2_f0", 32'd4);
        check_flag("run2_f1", 32'd4);
        check_flag("run2_f2", 32'd8);

        // Zero sets: header read then straight to done
        build(0, 0);
        pulse_start();
        wait_for("run3_flags", 1, 1, 100);
        repeat (5) @(posedge clk);
        #1;
        check("run3_rd_cnt", 64'(rd_cnt), 64'd1);
        check("run3_wr_n", 64'(wr_log.size()), 64'd0);
        check("run3_flag_n", 64'(flag_log.size()), 64'd1);
        check_flag("run3_f0", 32'd8);

        // Reset in the middle of the window stream, then restart
        build(1, 0);
        pulse_start();
        wait_for("run4_win", 0, 100, 2000);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_quiet("midrst");
        @(posedge clk); #1 rst = 1'b0;
        build(1, 0);
        repeat (10) @(posedge clk);
        #1;
        check("midrst_no_rd", 64'(rd_cnt), 64'd0);
        check("midrst_no_wr", 64'(wr_log.size()), 64'd0);
        log_wr = 0;
        pci_req_addr = 21'h10; pci_wr_en = 1'b1;
        @(negedge clk);
        check("midrst_idle_mirror", 64'(mem.FPGA_wr_en), 64'd1);
        @(posedge clk); #1 pci_wr_en = 1'b0; pci_req_addr = '0; log_wr = 1;
        pulse_start();
        wait_for("run4b_win", 0, 1600, 20000);
        pulse_eng(64'h0000_0003_8000_0000, 13'd5);
        wait_for("run4b_flags", 1, 2, 100);
        check_stream("run4b", 1);
        check_wr("run4b_w0", RES_BASE, 32'h3);
        check_flag("run4b_f0", 32'd4);
        check_flag("run4b_f1", 32'd8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
